// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared modulator constants and serializer state encoding
package word_serializer_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DIV_W_DEF = 16;
  localparam logic IDLE_LEVEL_DEF = 1'b0;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/word_serializer_bit_period_cnt.sv
// bit_period_cnt: period counter 0..limit with synchronous clear and end-of-period tick
module bit_period_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tick
);
  assign tick = en && (count == limit);
  // count up while enabled, wrap to zero at the end of each period
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (en) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/word_serializer.sv
// word_serializer: loads a word and shifts it out one bit per programmable period
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int   DATA_W     = DATA_W_DEF,
  parameter int   DIV_W      = DIV_W_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic [DIV_W-1:0]  div,
  input  logic              msb_first,
  output logic              ready,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_strobe,
  output logic              done
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0] bcnt, bcnt_n;
  logic [DIV_W-1:0] div_q, div_n, pcnt;
  logic msb_q, msb_n, bit_n, strobe_n, done_n, tick, last;
  assign ready = state == IDLE;
  assign busy = state == SHIFT;
  assign last = bcnt == CW'(DATA_W - 1);
  bit_period_cnt #(.W(DIV_W)) u_period (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .en   (state == SHIFT),
    .limit(div_q),
    .count(pcnt),
    .tick (tick)
  );
  // next state: latch a word on load, advance one bit per period tick, finish after the last bit
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n = bcnt;
    div_n = div_q;
    msb_n = msb_q;
    bit_n = bit_out;
    strobe_n = 1'b0;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        state_n = SHIFT;
        div_n = div;
        msb_n = msb_first;
        bcnt_n = '0;
        bit_n = msb_first ? data_in[DATA_W-1] : data_in[0];
        shreg_n = msb_first ? data_in << 1 : data_in >> 1;
        strobe_n = 1'b1;
      end
    end else if (tick) begin
      if (last) begin
        state_n = IDLE;
        bit_n = IDLE_LEVEL;
        done_n = 1'b1;
      end else begin
        bcnt_n = bcnt + 1'b1;
        bit_n = msb_q ? shreg[DATA_W-1] : shreg[0];
        shreg_n = msb_q ? shreg << 1 : shreg >> 1;
        strobe_n = 1'b1;
      end
    end
  end
  // register all state and outputs; reset aborts any word in flight
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bcnt <= '0;
      div_q <= '0;
      msb_q <= 1'b0;
      bit_out <= IDLE_LEVEL;
      bit_strobe <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bcnt <= bcnt_n;
      div_q <= div_n;
      msb_q <= msb_n;
      bit_out <= bit_n;
      bit_strobe <= strobe_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: randomized self-checking bench against a per-cycle output model
module tb_word_serializer;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, msb_first = 1'b0;
  logic [31:0] data_in = '0;
  logic [15:0] div = '0;
  logic ready, busy, bit_out, bit_strobe, done;
  logic [4:0] obs;
  int compared = 0, mismatched = 0;

  assign obs = {ready, busy, bit_out, bit_strobe, done};

  word_serializer dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .div(div),
    .msb_first(msb_first), .ready(ready), .busy(busy), .bit_out(bit_out),
    .bit_strobe(bit_strobe), .done(done)
  );

  always #5 clk = ~clk;

  // expected {ready,busy,bit_out,bit_strobe,done} j cycles after the load edge
  function automatic logic [4:0] model(logic [31:0] d, int dv, bit m, int j);
    int p = dv + 1;
    int n;
    if (j < 32 * p) begin
      n = j / p;
      return {1'b0, 1'b1, m ? d[31-n] : d[n], (j % p) == 0, 1'b0};
    end
    if (j == 32 * p) return 5'b10001;
    return 5'b10000;
  endfunction

  // load one word and follow it to the done cycle; mode 1 noise, 2 load-while-busy, 3 div change, 4 reset at bit 10
  task automatic send_word(input logic [31:0] d, input int dv, input bit m, input int mode, input string name);
    int p = dv + 1;
    logic [4:0] want;
    compared++;
    if (ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s ready_before_load got=%b want=1", name, ready);
    end
    data_in = d;
    div = dv[15:0];
    msb_first = m;
    load = 1'b1;
    for (int j = 0; j <= 32 * p; j++) begin
      @(posedge clk); #1;
      load = 1'b0;
      want = model(d, dv, m, j);
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL %s cycle=%0d got=%b want=%b", name, j, obs, want);
      end
      if (mode == 1 && j < 32 * p) begin
        data_in = $urandom;
        div = 16'($urandom);
        msb_first = 1'($urandom);
        load = 1'($urandom);
      end
      if (mode == 2) begin
        load = j >= 5 && j < 9;
        data_in = load ? 32'hFFFF_FFFF : d;
      end
      if (mode == 3 && j == 10) div = 16'd7;
      if (mode == 4 && j == 10 * p) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        compared++;
        if (obs !== 5'b10000) begin
          mismatched++;
          $display("FAIL %s after_abort got=%b want=10000", name, obs);
        end
        return;
      end
    end
  endtask

  // idle cycles with load low and noisy data: nothing may move
  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      data_in = $urandom;
      div = 16'($urandom);
      msb_first = 1'($urandom);
      @(posedge clk); #1;
      compared++;
      if (obs !== 5'b10000) begin
        mismatched++;
        $display("FAIL %s idle=%0d got=%b want=10000", name, i, obs);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (obs !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_values got=%b want=10000", obs);
    end
    load = 1'b1;
    data_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    compared++;
    if (obs !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_with_load got=%b want=10000", obs);
    end
    load = 1'b0;
    reset = 1'b0;
    idle_check(2, "post_reset");
  endtask

  task automatic test_msb_basic();
    send_word(32'hA5A5_0F0F, 0, 1'b1, 0, "msb_basic");
    idle_check(3, "msb_basic");
  endtask

  task automatic test_lsb_divided();
    send_word(32'h0000_0001, 3, 1'b0, 0, "lsb_div3");
    idle_check(2, "lsb_div3");
  endtask

  task automatic test_load_while_busy();
    send_word(32'hC3A5_1E70, 1, 1'b1, 2, "load_busy");
    idle_check(2, "load_busy");
  endtask

  task automatic test_back_to_back();
    send_word(32'h5A5A_F0F0, 0, 1'b1, 0, "b2b_first");
    send_word(32'h8000_0001, 0, 1'b1, 0, "b2b_second");
    idle_check(2, "b2b");
  endtask

  task automatic test_reset_mid_word();
    send_word($urandom, 2, 1'b1, 4, "abort");
    idle_check(40, "abort_no_done");
    send_word(32'h1234_5678, 0, 1'b1, 0, "after_abort");
    idle_check(2, "after_abort");
  endtask

  task automatic test_div_change();
    send_word($urandom, 1, 1'b0, 3, "div_change");
    idle_check(2, "div_change");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      send_word($urandom, $urandom_range(0, 3), 1'($urandom), 1, "random");
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 4), "random_gap");
    end
    idle_check(2, "random_end");
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_divided();
    test_load_while_busy();
    test_back_to_back();
    test_reset_mid_word();
    test_div_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
